// File: rtl/bsg_token_bucket_gate_pkg.sv
// Shared helpers for the token bucket gate: output buffer state encoding and token width.
package bsg_token_bucket_gate_pkg;

   typedef enum logic {
      e_one_fifo_empty = 1'b0,
      e_one_fifo_full  = 1'b1
   } one_fifo_state_e;

   // Bits needed to hold the values 0..max_tokens inclusive
   function automatic int unsigned tok_width(input int unsigned max_tokens);
      return (max_tokens < 1) ? 1 : $clog2(max_tokens + 1);
   endfunction

endpackage

// File: rtl/bsg_one_fifo.sv
// One-entry buffer with registered outputs; a full entry can be replaced in the cycle it drains.
module bsg_one_fifo
   import bsg_token_bucket_gate_pkg::*;
#(
   parameter int unsigned width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_and_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               ready_and_i
);

   one_fifo_state_e    state_r, state_n;
   logic [width_p-1:0] data_r;
   logic               enq, deq;

   always_ff @(posedge clk_i) begin
      if (reset_i) state_r <= e_one_fifo_empty;
      else         state_r <= state_n;
   end

   // Payload needs no reset; v_o qualifies it
   always_ff @(posedge clk_i) begin
      if (enq) data_r <= data_i;
   end

   always_comb begin
      state_n     = state_r;
      ready_and_o = 1'b1;
      enq         = 1'b0;
      deq         = 1'b0;
      unique case (state_r)
         e_one_fifo_empty: begin
            ready_and_o = 1'b1;
            enq         = v_i;
            if (enq) state_n = e_one_fifo_full;
         end
         e_one_fifo_full: begin
            deq         = ready_and_i;
            ready_and_o = ready_and_i;
            enq         = v_i & ready_and_i;
            if (deq & ~enq) state_n = e_one_fifo_empty;
         end
      endcase
   end

   assign v_o    = (state_r == e_one_fifo_full);
   assign data_o = data_r;

endmodule

// File: rtl/bsg_token_bucket_gate.sv
// Token-bucket rate limiter for a ready/valid stream; tick_i refills, each limited accept costs one token.
module bsg_token_bucket_gate
   import bsg_token_bucket_gate_pkg::*;
#(
   parameter  int unsigned width_p           = 8,
   parameter  int unsigned max_tokens_p      = 4,
   parameter  int unsigned init_tokens_p     = max_tokens_p,
   parameter  int unsigned tokens_per_tick_p = 1,
   localparam int unsigned tok_width_lp      = tok_width(max_tokens_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    tick_i,
   input  logic                    limit_en_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    ready_and_o,
   output logic                    v_o,
   output logic [width_p-1:0]      data_o,
   input  logic                    ready_and_i,
   output logic [tok_width_lp-1:0] tokens_o
);

   localparam int unsigned sum_width_lp = tok_width_lp + 1;
   localparam logic [sum_width_lp-1:0] max_ext_lp = sum_width_lp'(max_tokens_p);

   logic [tok_width_lp-1:0] tokens_r, tokens_n;
   logic [sum_width_lp-1:0] add, sub, sum;
   logic                    tok_ok, buf_ready, accept;

   // Gate on the registered count only, so a same-cycle tick never opens the gate
   assign tok_ok      = ~limit_en_i | (tokens_r != '0);
   assign ready_and_o = buf_ready & tok_ok;
   assign accept      = v_i & ready_and_o;

   bsg_one_fifo #(
      .width_p (width_p)
   ) out_buf (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .v_i         (v_i & tok_ok),
      .data_i      (data_i),
      .ready_and_o (buf_ready),
      .v_o         (v_o),
      .data_o      (data_o),
      .ready_and_i (ready_and_i)
   );

   // One extra bit of headroom so refill saturates instead of wrapping
   always_comb begin
      add      = tick_i ? sum_width_lp'(tokens_per_tick_p) : '0;
      sub      = sum_width_lp'(accept & limit_en_i);
      sum      = {1'b0, tokens_r} + add - sub;
      tokens_n = (sum > max_ext_lp) ? max_ext_lp[tok_width_lp-1:0] : sum[tok_width_lp-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) tokens_r <= tok_width_lp'(init_tokens_p);
      else         tokens_r <= tokens_n;
   end

   assign tokens_o = tokens_r;

`ifndef SYNTHESIS
   a_init_le_max: assert property (@(posedge clk_i) init_tokens_p <= max_tokens_p)
      else $error("init_tokens_p exceeds max_tokens_p");
   a_tpt_le_max: assert property (@(posedge clk_i) tokens_per_tick_p <= max_tokens_p)
      else $error("tokens_per_tick_p exceeds max_tokens_p");
   a_tok_le_max: assert property (@(posedge clk_i) disable iff (reset_i)
                                  {1'b0, tokens_r} <= max_ext_lp)
      else $error("token count exceeds max_tokens_p");
`endif

endmodule

// File: tb/tb_bsg_token_bucket_gate.sv
// Bench for bsg_token_bucket_gate: directed scenarios plus random traffic on two configurations.
module tb_bsg_token_bucket_gate;

   localparam int unsigned W     = 8;
   localparam int unsigned MAX0  = 4;
   localparam int unsigned INIT0 = 4;
   localparam int unsigned TPT0  = 1;
   localparam int unsigned MAX1  = 6;
   localparam int unsigned INIT1 = 3;
   localparam int unsigned TPT1  = 4;
   localparam int unsigned TW0   = $clog2(MAX0 + 1);
   localparam int unsigned TW1   = $clog2(MAX1 + 1);

   logic           clk = 1'b0;
   logic           reset = 1'b1, tick = 1'b0, limit_en = 1'b1, v = 1'b0, rdy_in = 1'b0;
   logic [W-1:0]   data = '0;
   logic           rdy0, vo0, rdy1, vo1;
   logic [W-1:0]   do0, do1;
   logic [TW0-1:0] tok0;
   logic [TW1-1:0] tok1;

   always #5 clk = ~clk;

   bsg_token_bucket_gate #(
      .width_p(W), .max_tokens_p(MAX0), .init_tokens_p(INIT0), .tokens_per_tick_p(TPT0)
   ) dut0 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick), .limit_en_i(limit_en), .v_i(v),
      .data_i(data), .ready_and_o(rdy0), .v_o(vo0), .data_o(do0), .ready_and_i(rdy_in),
      .tokens_o(tok0)
   );

   bsg_token_bucket_gate #(
      .width_p(W), .max_tokens_p(MAX1), .init_tokens_p(INIT1), .tokens_per_tick_p(TPT1)
   ) dut1 (
      .clk_i(clk), .reset_i(reset), .tick_i(tick), .limit_en_i(limit_en), .v_i(v),
      .data_i(data), .ready_and_o(rdy1), .v_o(vo1), .data_o(do1), .ready_and_i(rdy_in),
      .tokens_o(tok1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: integer bucket and a word queue per instance
   int          m_max [2] = '{MAX0, MAX1};
   int          m_init[2] = '{INIT0, INIT1};
   int          m_tpt [2] = '{TPT0, TPT1};
   int          m_tok [2];
   logic [W-1:0] m_q0[$];
   logic [W-1:0] m_q1[$];
   bit          m_known = 1'b0;
   int          acc_cnt0 = 0;
   int          out_cnt0 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int q_size(input int i);
      return (i == 0) ? m_q0.size() : m_q1.size();
   endfunction

   function automatic bit m_ready(input int i);
      return (q_size(i) == 0 || rdy_in) && (!limit_en || m_tok[i] > 0);
   endfunction

   task automatic compare_outputs();
      check("rdy0", 32'(rdy0), 32'(m_ready(0)));
      check("vo0",  32'(vo0),  32'(q_size(0) != 0));
      check("tok0", 32'(tok0), 32'(m_tok[0]));
      if (m_q0.size() != 0) check("data0", 32'(do0), 32'(m_q0[0]));
      check("rdy1", 32'(rdy1), 32'(m_ready(1)));
      check("vo1",  32'(vo1),  32'(q_size(1) != 0));
      check("tok1", 32'(tok1), 32'(m_tok[1]));
      if (m_q1.size() != 0) check("data1", 32'(do1), 32'(m_q1[0]));
   endtask

   task automatic model_update(input int i);
      bit acc, deq;
      int nt;
      if (reset) begin
         if (i == 0) m_q0.delete(); else m_q1.delete();
         m_tok[i] = m_init[i];
      end else begin
         acc = v && m_ready(i);
         deq = (q_size(i) != 0) && rdy_in;
         if (i == 0) begin
            if (deq) void'(m_q0.pop_front());
            if (acc) m_q0.push_back(data);
         end else begin
            if (deq) void'(m_q1.pop_front());
            if (acc) m_q1.push_back(data);
         end
         nt = m_tok[i] + (tick ? m_tpt[i] : 0) - ((acc && limit_en) ? 1 : 0);
         m_tok[i] = (nt > m_max[i]) ? m_max[i] : nt;
      end
   endtask

   // One clock: drive at negedge, compare 1 time unit later, advance model at posedge
   task automatic cycle(input bit r, input bit t, input bit l, input bit vv, input bit ri,
                        input logic [W-1:0] d);
      @(negedge clk);
      reset = r; tick = t; limit_en = l; v = vv; rdy_in = ri; data = d;
      #1;
      if (m_known) compare_outputs();
      if (!r && vv && rdy0) acc_cnt0++;
      if (!r && vo0 && ri) out_cnt0++;
      @(posedge clk);
      model_update(0);
      model_update(1);
      if (r) m_known = 1'b1;
   endtask

   initial begin
      logic [W-1:0] dval;

      cycle(1, 0, 1, 0, 1, 8'h00);
      cycle(1, 1, 1, 1, 1, 8'h11);
      @(negedge clk); #1;
      check("reset_tok0", 32'(tok0), INIT0);
      check("reset_vo0",  32'(vo0), 0);

      // Full bucket drains in exactly four back-to-back accepts
      acc_cnt0 = 0;
      for (int k = 0; k < 7; k++) cycle(0, 0, 1, 1, 1, W'(8'h20 + k));
      check("t1_accepts", 32'(acc_cnt0), 4);
      check("t1_tok0", 32'(m_tok[0]), 0);

      // Tick with an empty bucket opens the gate only in the next cycle
      acc_cnt0 = 0;
      cycle(0, 1, 1, 1, 1, 8'h31);
      check("t2_tick_cycle_acc", 32'(acc_cnt0), 0);
      cycle(0, 0, 1, 1, 1, 8'h32);
      cycle(0, 0, 1, 1, 1, 8'h33);
      check("t2_accepts", 32'(acc_cnt0), 1);

      // Tick every 4th cycle from a mod-4 counter: steady 1 word per 4 cycles
      for (int k = 0; k < 8; k++) cycle(0, (k % 4) == 3, 1, 1, 1, W'(8'h40 + k));
      out_cnt0 = 0;
      for (int k = 8; k < 40; k++) cycle(0, (k % 4) == 3, 1, 1, 1, W'(8'h40 + k));
      check("t4_rate", 32'(out_cnt0), 8);

      // Refill to full, then tick and accept together stays saturated
      for (int k = 0; k < 6; k++) cycle(0, 1, 1, 0, 1, 8'h00);
      cycle(0, 1, 1, 1, 1, 8'h55);
      @(negedge clk); #1;
      check("t3_tick_acc_full", 32'(tok0), MAX0);
      for (int k = 0; k < 10; k++) cycle(0, 1, 1, 0, 1, 8'h00);
      check("t3_sat_tok0", 32'(m_tok[0]), MAX0);

      // Backpressure holds the word and the tokens; release drains and refills
      cycle(0, 0, 1, 1, 0, 8'h60);
      for (int k = 1; k < 6; k++) cycle(0, 0, 1, 1, 0, W'(8'h60 + k));
      @(negedge clk); #1;
      check("t5_hold_data", 32'(do0), 32'h60);
      check("t5_hold_tok", 32'(tok0), MAX0 - 1);
      acc_cnt0 = 0;
      cycle(0, 0, 1, 1, 1, 8'h6A);
      check("t5_release_acc", 32'(acc_cnt0), 1);

      // Unlimited mode with an empty bucket passes at full rate
      for (int k = 0; k < 5; k++) cycle(0, 0, 1, 1, 1, W'(8'h70 + k));
      acc_cnt0 = 0;
      for (int k = 0; k < 8; k++) cycle(0, 0, 0, 1, 1, W'(8'h80 + k));
      check("t6_passthru", 32'(acc_cnt0), 8);
      check("t6_tok0", 32'(m_tok[0]), 0);
      cycle(1, 0, 0, 1, 1, 8'h90);
      @(negedge clk); #1;
      check("t6_reset_vo0", 32'(vo0), 0);
      check("t6_reset_tok0", 32'(tok0), INIT0);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         dval = W'($urandom);
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, dval);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
